screen_tx_sched: RTL and testbench

- Message-level scheduler in front of the UART screen transmitter (10-bit frame in, dataValid/inputReady handshake, 9600 baud at 50 MHz).
- Shares the transmitter between two byte-stream clients: client 0 is the note/key display, client 1 is the status/score display.
- Wraps each data byte into a UART frame and sequences the transmitter's handshake.
- Holds the grant for a whole message and inserts a settle gap after each message so the serial LCD can process commands.

---
 rtl/screen_pkg.sv | 22 ++
 rtl/screen_tx_sched_if.sv | 35 +++
 rtl/screen_rr_arb.sv | 18 +
 rtl/screen_tx_sched.sv | 166 ++++++++++++++++
 tb/tb_screen_tx_sched.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/screen_pkg.sv
// Shared types and frame helper for the UART screen transmit scheduler.
package screen_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      SEND,
      WAIT_ACK,
      WAIT_DONE,
      GAP
   } state_t;

   localparam int   FRAME_BITS = 10;
   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;

   // bit0 leaves the transmitter first, so the start bit sits at the LSB
   function automatic logic [FRAME_BITS-1:0] make_frame(input logic [7:0] data);
      return {STOP_BIT, data, START_BIT};
   endfunction

endpackage

// File: rtl/screen_tx_sched_if.sv
// Client byte streams plus the transmitter handshake, bundled between scheduler and its peers.
interface screen_tx_sched_if;
   import screen_pkg::*;

   logic                  c0_valid;
   logic [7:0]            c0_data;
   logic                  c0_last;
   logic                  c0_ready;
   logic                  c1_valid;
   logic [7:0]            c1_data;
   logic                  c1_last;
   logic                  c1_ready;
   logic [FRAME_BITS-1:0] tx_frame;
   logic                  tx_valid;
   logic                  tx_ready;

   modport slave (
      input  c0_valid, c0_data, c0_last,
      output c0_ready,
      input  c1_valid, c1_data, c1_last,
      output c1_ready,
      output tx_frame, tx_valid,
      input  tx_ready
   );

   modport master (
      output c0_valid, c0_data, c0_last,
      input  c0_ready,
      output c1_valid, c1_data, c1_last,
      input  c1_ready,
      input  tx_frame, tx_valid,
      output tx_ready
   );

endinterface

// File: rtl/screen_rr_arb.sv
// Two-way round-robin pick: the pointer only matters when both clients request.
module screen_rr_arb (
   input  logic [1:0] req,
   input  logic       pointer,
   output logic       gnt_idx,
   output logic       any_req
);

   assign any_req = |req;

   always_comb begin
      gnt_idx = req[1];
      if (req == 2'b11) begin
         gnt_idx = pointer;
      end
   end

endmodule

// File: rtl/screen_tx_sched.sv
// Shares one UART screen transmitter between two message clients, holding the grant
// for a whole message and leaving a settle gap afterwards for the LCD.
module screen_tx_sched
   import screen_pkg::*;
#(
   parameter int GAP_CYCLES  = 50000,
   parameter int ACK_TIMEOUT = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   screen_tx_sched_if.slave   bus,
   output logic               grant,
   output logic               busy,
   output logic               proto_err
);

   localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam int TMO_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
   localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(ACK_TIMEOUT);

   state_t                state_reg, state_next;
   logic                  grant_reg, grant_next;
   logic                  busy_reg, busy_next;
   logic                  err_reg, err_next;
   logic                  rr_reg, rr_next;
   logic [GAP_W-1:0]      gap_reg, gap_next;
   logic [TMO_W-1:0]      tmo_reg, tmo_next;
   logic [7:0]            data_reg, data_next;
   logic                  last_reg, last_next;
   logic                  tx_valid_reg, tx_valid_next;
   logic [FRAME_BITS-1:0] tx_frame_reg, tx_frame_next;

   logic       arb_idx;
   logic       arb_any;
   logic       fetch_valid;
   logic [7:0] fetch_data;
   logic       fetch_last;

   screen_rr_arb u_arb (
      .req     ({bus.c1_valid, bus.c0_valid}),
      .pointer (rr_reg),
      .gnt_idx (arb_idx),
      .any_req (arb_any)
   );

   assign fetch_valid = grant_reg ? bus.c1_valid : bus.c0_valid;
   assign fetch_data  = grant_reg ? bus.c1_data  : bus.c0_data;
   assign fetch_last  = grant_reg ? bus.c1_last  : bus.c0_last;

   assign bus.c0_ready = (state_reg == FETCH) && !grant_reg && bus.c0_valid;
   assign bus.c1_ready = (state_reg == FETCH) &&  grant_reg && bus.c1_valid;
   assign bus.tx_valid = tx_valid_reg;
   assign bus.tx_frame = tx_frame_reg;
   assign grant        = grant_reg;
   assign busy         = busy_reg;
   assign proto_err    = err_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= IDLE;
         grant_reg    <= 1'b0;
         busy_reg     <= 1'b0;
         err_reg      <= 1'b0;
         rr_reg       <= 1'b0;
         gap_reg      <= '0;
         tmo_reg      <= '0;
         data_reg     <= '0;
         last_reg     <= 1'b0;
         tx_valid_reg <= 1'b0;
         tx_frame_reg <= '1;
      end else begin
         state_reg    <= state_next;
         grant_reg    <= grant_next;
         busy_reg     <= busy_next;
         err_reg      <= err_next;
         rr_reg       <= rr_next;
         gap_reg      <= gap_next;
         tmo_reg      <= tmo_next;
         data_reg     <= data_next;
         last_reg     <= last_next;
         tx_valid_reg <= tx_valid_next;
         tx_frame_reg <= tx_frame_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      grant_next    = grant_reg;
      busy_next     = busy_reg;
      err_next      = err_reg;
      rr_next       = rr_reg;
      gap_next      = gap_reg;
      tmo_next      = tmo_reg;
      data_next     = data_reg;
      last_next     = last_reg;
      tx_valid_next = 1'b0;
      tx_frame_next = tx_frame_reg;

      case (state_reg)
         IDLE: begin
            if (arb_any) begin
               grant_next = arb_idx;
               busy_next  = 1'b1;
               state_next = FETCH;
            end
         end
         FETCH: begin
            if (fetch_valid) begin
               data_next  = fetch_data;
               last_next  = fetch_last;
               state_next = SEND;
            end
         end
         SEND: begin
            // The transmitter latches on tx_valid alone, so only pulse while it is idle
            if (bus.tx_ready) begin
               tx_valid_next = 1'b1;
               tx_frame_next = make_frame(data_reg);
               tmo_next      = TMO_LOAD;
               state_next    = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (!bus.tx_ready) begin
               state_next = WAIT_DONE;
            end else if (tmo_reg <= TMO_W'(1)) begin
               tmo_next   = '0;
               err_next   = 1'b1;
               state_next = WAIT_DONE;
            end else begin
               tmo_next = tmo_reg - TMO_W'(1);
            end
         end
         WAIT_DONE: begin
            if (bus.tx_ready) begin
               if (last_reg) begin
                  rr_next = ~grant_reg;
                  if (GAP_CYCLES == 0) begin
                     busy_next  = 1'b0;
                     state_next = IDLE;
                  end else begin
                     gap_next   = GAP_LOAD;
                     state_next = GAP;
                  end
               end else begin
                  state_next = FETCH;
               end
            end
         end
         GAP: begin
            if (gap_reg <= GAP_W'(1)) begin
               gap_next   = '0;
               busy_next  = 1'b0;
               state_next = IDLE;
            end else begin
               gap_next = gap_reg - GAP_W'(1);
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_screen_tx_sched.sv
// Directed bench for screen_tx_sched with a simple transmitter model and two queued clients.
module tb_screen_tx_sched;

   localparam int GAP     = 16;
   localparam int ACK_TO  = 4;
   localparam int TX_BUSY = 20;

   logic clk = 1'b0;
   logic reset_n = 1'b1;
   logic grant;
   logic busy;
   logic proto_err;
   logic fault = 1'b0;

   screen_tx_sched_if bus();

   screen_tx_sched #(
      .GAP_CYCLES  (GAP),
      .ACK_TIMEOUT (ACK_TO)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .bus       (bus.slave),
      .grant     (grant),
      .busy      (busy),
      .proto_err (proto_err)
   );

   always #5 clk = ~clk;

   logic [8:0] q0[$];
   logic [8:0] q1[$];
   logic [9:0] fq[$];
   logic       gq[$];
   int rdy0 = 0;
   int rdy1 = 0;
   int pulses = 0;
   int bad_valid = 0;
   int tx_cnt;

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   // Transmitter model: drops ready for TX_BUSY+1 cycles after accepting a frame
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.tx_ready <= 1'b1;
         tx_cnt       <= 0;
      end else if (!bus.tx_ready) begin
         if (tx_cnt == 0) bus.tx_ready <= 1'b1;
         else             tx_cnt <= tx_cnt - 1;
      end else if (bus.tx_valid && !fault) begin
         bus.tx_ready <= 1'b0;
         tx_cnt       <= TX_BUSY;
      end
   end

   always @(posedge clk) begin
      if (reset_n) begin
         if (bus.c0_ready) begin
            void'(q0.pop_front());
            rdy0++;
         end
         if (bus.c1_ready) begin
            void'(q1.pop_front());
            rdy1++;
         end
         if (bus.tx_valid) begin
            fq.push_back(bus.tx_frame);
            gq.push_back(grant);
            pulses++;
            if (!bus.tx_ready) bad_valid++;
         end
      end
   end

   always @(negedge clk) begin
      logic [8:0] h0;
      logic [8:0] h1;
      h0 = (q0.size() != 0) ? q0[0] : 9'h000;
      h1 = (q1.size() != 0) ? q1[0] : 9'h000;
      bus.c0_valid = (q0.size() != 0);
      bus.c0_data  = h0[7:0];
      bus.c0_last  = h0[8];
      bus.c1_valid = (q1.size() != 0);
      bus.c1_data  = h1[7:0];
      bus.c1_last  = h1[8];
   end

   task automatic wait_idle(input string tag);
      int n = 0;
      while (n < 3000 && !(busy == 1'b0 && q0.size() == 0 && q1.size() == 0 && bus.tx_ready)) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(n < 3000), 32'd1);
   endtask

   task automatic wait_frames(input int cnt, input string tag);
      int n = 0;
      while (fq.size() < cnt && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(fq.size() >= cnt), 32'd1);
   endtask

   initial begin
      int f, b, r0, r1, n;
      bus.c0_valid = 1'b0; bus.c0_data = 8'h00; bus.c0_last = 1'b0;
      bus.c1_valid = 1'b0; bus.c1_data = 8'h00; bus.c1_last = 1'b0;
      #1 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_tx_valid", bus.tx_valid, 1'b0);
      chk("rst_tx_frame", bus.tx_frame, 10'h3FF);
      chk("rst_grant", grant, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_proto_err", proto_err, 1'b0);
      reset_n = 1'b1;
      @(negedge clk);

      // Single byte from client 0, gap measured from tx_ready returning high
      f = fq.size(); b = pulses; r0 = rdy0;
      q0.push_back({1'b1, 8'h41});
      wait_frames(f + 1, "t1_frame_seen");
      chk("t1_frame", fq[f], 10'h282);
      chk("t1_grant", gq[f], 1'b0);
      n = 0;
      while (!bus.tx_ready && n < 500) begin @(negedge clk); n++; end
      n = 0;
      while (busy && n < 500) begin @(negedge clk); n++; end
      // WAIT_DONE cycle plus GAP settle cycles
      chk("t1_busy_hold", n, GAP + 1);
      wait_idle("t1_idle");
      chk("t1_ready_pulses", rdy0 - r0, 1);
      chk("t1_tx_pulses", pulses - b, 1);

      // Three-byte message from client 1
      f = fq.size(); r1 = rdy1;
      q1.push_back({1'b0, 8'hFE});
      q1.push_back({1'b0, 8'h01});
      q1.push_back({1'b1, 8'h80});
      wait_idle("t2_idle");
      chk("t2_frame0", fq[f],     10'h3FC);
      chk("t2_frame1", fq[f + 1], 10'h202);
      chk("t2_frame2", fq[f + 2], 10'h300);
      chk("t2_grants", {gq[f], gq[f + 1], gq[f + 2]}, 3'b111);
      chk("t2_ready_pulses", rdy1 - r1, 3);

      // Contention twice; pointer is 0 after client 1 finished
      f = fq.size();
      q0.push_back({1'b1, 8'h11});
      q1.push_back({1'b1, 8'h22});
      wait_idle("t3_idle_a");
      q0.push_back({1'b1, 8'h33});
      q1.push_back({1'b1, 8'h44});
      wait_idle("t3_idle_b");
      chk("t3_count", fq.size() - f, 4);
      chk("t3_frame0", fq[f],     10'h222);
      chk("t3_frame1", fq[f + 1], 10'h244);
      chk("t3_frame2", fq[f + 2], 10'h266);
      chk("t3_frame3", fq[f + 3], 10'h288);
      chk("t3_grant_order", {gq[f], gq[f + 1], gq[f + 2], gq[f + 3]}, 4'b0101);

      // Client 0 stalls mid-message while client 1 waits
      f = fq.size(); r0 = rdy0; r1 = rdy1;
      q0.push_back({1'b0, 8'hA5});
      n = 0;
      while (rdy0 == r0 && n < 500) begin @(negedge clk); n++; end
      q1.push_back({1'b1, 8'h77});
      repeat (1000) @(negedge clk);
      chk("t4_grant_held", grant, 1'b0);
      chk("t4_busy_held", busy, 1'b1);
      chk("t4_no_c1_ready", rdy1 - r1, 0);
      q0.push_back({1'b1, 8'h5A});
      wait_idle("t4_idle");
      chk("t4_frame0", fq[f],     10'h34A);
      chk("t4_frame1", fq[f + 1], 10'h2B4);
      chk("t4_frame2", fq[f + 2], 10'h2EE);
      chk("t4_grant_order", {gq[f], gq[f + 1], gq[f + 2]}, 3'b001);

      // Transmitter never drops ready
      fault = 1'b1;
      f = fq.size(); b = pulses;
      chk("t5_err_before", proto_err, 1'b0);
      q0.push_back({1'b1, 8'h0F});
      wait_frames(f + 1, "t5_frame_seen");
      chk("t5_frame", fq[f], 10'h21E);
      n = 0;
      while (!proto_err && n < 20) begin @(negedge clk); n++; end
      // first negedge counted here is one edge after tx_valid rose
      chk("t5_err_latency", n, ACK_TO - 1);
      wait_idle("t5_idle");
      fault = 1'b0;
      repeat (5) @(negedge clk);
      chk("t5_err_sticky", proto_err, 1'b1);
      chk("t5_single_pulse", pulses - b, 1);

      // Reset during WAIT_ACK of the second byte
      f = fq.size();
      q1.push_back({1'b0, 8'hC3});
      q1.push_back({1'b1, 8'h3C});
      wait_frames(f + 2, "t6_second_frame");
      reset_n = 1'b0;
      #1;
      chk("t6_tx_valid", bus.tx_valid, 1'b0);
      chk("t6_tx_frame", bus.tx_frame, 10'h3FF);
      chk("t6_busy", busy, 1'b0);
      chk("t6_grant", grant, 1'b0);
      chk("t6_err_cleared", proto_err, 1'b0);
      q0.delete();
      q1.delete();
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      f = fq.size(); r1 = rdy1;
      q1.push_back({1'b1, 8'h99});
      wait_idle("t6_idle");
      chk("t6_frame", fq[f], 10'h332);
      chk("t6_grant_after", gq[f], 1'b1);
      chk("t6_ready_pulses", rdy1 - r1, 1);

      chk("valid_only_when_ready", bad_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
